// File: rtl/gan_param_loader_pkg.sv
// Shared constants and types for the GAN parameter loader and the datapath it feeds.
package gan_param_loader_pkg;

  localparam int GAN_WORD_W      = 6;
  localparam int GAN_N_WORDS     = 77;
  localparam int GAN_HOLD_CYCLES = 40;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_HOLD   = 3'd3,
    ST_PEND   = 3'd4
  } ld_state_e;

  // Frame layout: inputs first, then for each layer its weights followed by its biases.
  // Layer widths 4-4-2-1-1-1-2-4-4 give 54 weights and 19 biases.
  localparam int OFS_X    = 0;
  localparam int OFS_W_L1 = 4;
  localparam int OFS_B_L1 = 20;
  localparam int OFS_W_L2 = 24;
  localparam int OFS_B_L2 = 32;
  localparam int OFS_W_L3 = 34;
  localparam int OFS_B_L3 = 36;
  localparam int OFS_W_L4 = 37;
  localparam int OFS_B_L4 = 38;
  localparam int OFS_W_L5 = 39;
  localparam int OFS_B_L5 = 40;
  localparam int OFS_W_L6 = 41;
  localparam int OFS_B_L6 = 43;
  localparam int OFS_W_L7 = 45;
  localparam int OFS_B_L7 = 53;
  localparam int OFS_W_L8 = 57;
  localparam int OFS_B_L8 = 73;
  localparam int OFS_END  = 77;

endpackage

// File: rtl/gan_param_loader_if.sv
// Word-stream input plus committed-frame output of the parameter loader.
interface gan_param_loader_if
  import gan_param_loader_pkg::*;
#(
  parameter int WORD_W  = GAN_WORD_W,
  parameter int N_WORDS = GAN_N_WORDS
) ();

  logic                      In_valid;
  logic [WORD_W-1:0]         In_data;
  logic                      In_last;
  logic                      In_ready;
  logic [N_WORDS*WORD_W-1:0] Param_bus;
  logic                      Start;
  logic                      Busy;
  logic                      Frame_err;

  modport master (
    output In_valid, In_data, In_last,
    input  In_ready, Param_bus, Start, Busy, Frame_err
  );

  modport slave (
    input  In_valid, In_data, In_last,
    output In_ready, Param_bus, Start, Busy, Frame_err
  );

endinterface

// File: rtl/gan_param_regfile.sv
// Double-buffered parameter storage: words stream into shadow, commit copies the
// whole frame into active in one edge so the datapath never sees a half frame.
module gan_param_regfile
  import gan_param_loader_pkg::*;
#(
  parameter int WORD_W  = GAN_WORD_W,
  parameter int N_WORDS = GAN_N_WORDS,
  parameter int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic                      commit,
  output logic [N_WORDS*WORD_W-1:0] param_bus
);

  logic [N_WORDS-1:0][WORD_W-1:0] shadow;
  logic [N_WORDS-1:0][WORD_W-1:0] active;

  // Shadow write port and shadow-to-active frame copy.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en)  shadow[wr_idx] <= wr_data;
      if (commit) active <= shadow;
    end
  end

  assign param_bus = active;

endmodule

// File: rtl/gan_param_loader.sv
// Loads a frame of signed parameter words, commits it atomically to Param_bus,
// pulses Start, then holds the frame stable for HOLD_CYCLES while the next frame
// may already stream into the shadow copy.
module gan_param_loader
  import gan_param_loader_pkg::*;
#(
  parameter int WORD_W      = GAN_WORD_W,
  parameter int N_WORDS     = GAN_N_WORDS,
  parameter int HOLD_CYCLES = GAN_HOLD_CYCLES
) (
  input logic              Clock,
  input logic              Reset,
  gan_param_loader_if.slave bus
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
  localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  ld_state_e        state, state_nx;
  logic [IDX_W-1:0] wcnt, wcnt_nx;
  logic [HC_W-1:0]  hold_cnt, hold_nx;
  logic             err, err_nx;
  logic             ready, xfer, at_last, frame_done, frame_bad, commit;

  // Ready is forced low while reset is held, independent of the state register.
  assign ready      = Reset && (state == ST_IDLE || state == ST_LOAD || state == ST_HOLD);
  assign xfer       = bus.In_valid && ready;
  assign at_last    = (wcnt == LAST_IDX);
  assign frame_done = xfer && at_last && bus.In_last;
  // In_last early, or missing on the final slot: either way the frame is malformed.
  assign frame_bad  = xfer && (at_last != bus.In_last);

  // State, word counter, hold counter and sticky error registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      wcnt     <= wcnt_nx;
      hold_cnt <= hold_nx;
      err      <= err_nx;
    end
  end

  // Next-state logic: word accounting first, then per-state sequencing.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    hold_nx  = hold_cnt;
    err_nx   = err;
    commit   = 1'b0;

    // A completed frame keeps wcnt at the last slot until COMMIT clears it.
    if (frame_bad) begin
      err_nx  = 1'b1;
      wcnt_nx = '0;
    end else if (xfer && !frame_done) begin
      wcnt_nx = wcnt + IDX_W'(1);
    end

    case (state)
      ST_IDLE, ST_LOAD: begin
        if (frame_done)           state_nx = ST_COMMIT;
        else if (wcnt_nx == '0)   state_nx = ST_IDLE;
        else                      state_nx = ST_LOAD;
      end
      ST_COMMIT: begin
        commit   = 1'b1;
        err_nx   = 1'b0;
        wcnt_nx  = '0;
        hold_nx  = HOLD_LOAD;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          if (frame_done)         state_nx = ST_COMMIT;
          else if (wcnt_nx == '0) state_nx = ST_IDLE;
          else                    state_nx = ST_LOAD;
        end else begin
          hold_nx  = hold_cnt - HC_W'(1);
          state_nx = frame_done ? ST_PEND : ST_HOLD;
        end
      end
      ST_PEND: begin
        if (hold_cnt == '0) state_nx = ST_COMMIT;
        else                hold_nx  = hold_cnt - HC_W'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  gan_param_regfile #(
    .WORD_W (WORD_W),
    .N_WORDS(N_WORDS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .Clock    (Clock),
    .Reset    (Reset),
    .wr_en    (xfer),
    .wr_idx   (wcnt),
    .wr_data  (bus.In_data),
    .commit   (commit),
    .param_bus(bus.Param_bus)
  );

  assign bus.In_ready  = ready;
  assign bus.Start     = (state == ST_COMMIT);
  assign bus.Busy      = (state == ST_HOLD) || (state == ST_PEND);
  assign bus.Frame_err = err;

endmodule
